// File: rtl/pipe_pkg.sv
// Shared pipeFlow types: per-stage arithmetic op selector and its helper function.
// Helpers work on a fixed maximum width; callers truncate to their own width (mod 2^WIDTH).
package pipe_pkg;

   typedef enum logic [1:0] {
      PIPE_OP_PASS,
      PIPE_OP_INC,
      PIPE_OP_DEC
   } pipe_op_e;

   localparam int unsigned PIPE_MAX_W = 64;

   function automatic logic [PIPE_MAX_W-1:0] pipe_apply_op(
      input pipe_op_e                op,
      input logic [PIPE_MAX_W-1:0]   data
   );
      logic [PIPE_MAX_W-1:0] res;
      case (op)
         PIPE_OP_INC: res = data + PIPE_MAX_W'(1);
         PIPE_OP_DEC: res = data - PIPE_MAX_W'(1);
         default:     res = data;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One elastic register stage: holds a valid/data pair and advances when empty or when the
// downstream stage advances.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 5,
   parameter pipe_op_e    OP    = PIPE_OP_INC
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             flush_i,
   input  logic             up_valid_i,
   input  logic [WIDTH-1:0] up_data_i,
   input  logic             dn_adv_i,
   output logic             adv_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic [WIDTH-1:0] w_next;

   assign adv_o  = !r_valid || dn_adv_i;
   assign w_next = WIDTH'(pipe_apply_op(OP, PIPE_MAX_W'(up_data_i)));

   // Data only loads with a valid beat, so the stage output holds while idle.
   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (flush_i) begin
         r_valid <= 1'b0;
      end else if (adv_o) begin
         r_valid <= up_valid_i;
         if (up_valid_i) begin
            r_data <= w_next;
         end
      end
   end

   assign valid_o = r_valid;
   assign data_o  = r_data;

endmodule

// File: rtl/pipe_elastic.sv
// Elastic valid/ready pipeline of DEPTH op stages with synchronous flush and an occupancy count.
// The ready chain is combinational from pipe_out_rdy back to pipe_in_rdy, so it never bubbles.
module pipe_elastic
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 4,
   parameter pipe_op_e    OP    = PIPE_OP_INC,
   localparam int unsigned OCC_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] input_val,
   input  logic             pipe_in_valid,
   output logic             pipe_in_rdy,
   input  logic             flush_i,
   output logic [WIDTH-1:0] output_val,
   output logic             pipe_out_valid,
   input  logic             pipe_out_rdy,
   output logic [OCC_W-1:0] occupancy_o
);

   logic [DEPTH-1:0] w_valid;
   logic [WIDTH-1:0] w_data [DEPTH];
   logic             w_adv0;
   logic             w_accept;
   logic             w_pop;
   logic [OCC_W-1:0] r_occ;
   logic [OCC_W-1:0] w_occ_d;

   // Each stage keeps its own adv scalar so the ready chain is not one self-dependent vector.
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      logic             w_adv;
      logic             w_dn_adv;
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;

      if (g == 0) begin : g_head
         assign w_up_valid = w_accept;
         assign w_up_data  = input_val;
      end else begin : g_body
         assign w_up_valid = w_valid[g-1];
         assign w_up_data  = w_data[g-1];
      end

      if (g == DEPTH - 1) begin : g_tail
         assign w_dn_adv = pipe_out_rdy;
      end else begin : g_mid
         assign w_dn_adv = g_stage[g+1].w_adv;
      end

      pipe_stage #(
         .WIDTH (WIDTH),
         .OP    (OP)
      ) u_stage (
         .clk_i      (clk_i),
         .reset_i    (reset_i),
         .flush_i    (flush_i),
         .up_valid_i (w_up_valid),
         .up_data_i  (w_up_data),
         .dn_adv_i   (w_dn_adv),
         .adv_o      (w_adv),
         .valid_o    (w_valid[g]),
         .data_o     (w_data[g])
      );
   end

   assign w_adv0         = g_stage[0].w_adv;
   assign pipe_in_rdy    = w_adv0 && !flush_i && reset_i;
   assign w_accept       = pipe_in_valid && pipe_in_rdy;
   assign pipe_out_valid = w_valid[DEPTH-1] && !flush_i;
   assign w_pop          = pipe_out_valid && pipe_out_rdy;
   assign output_val     = w_data[DEPTH-1];

   always_comb begin
      w_occ_d = r_occ;
      case ({w_accept, w_pop})
         2'b10:   w_occ_d = r_occ + OCC_W'(1);
         2'b01:   w_occ_d = r_occ - OCC_W'(1);
         default: w_occ_d = r_occ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         r_occ <= '0;
      end else if (flush_i) begin
         r_occ <= '0;
      end else begin
         r_occ <= w_occ_d;
      end
   end

   assign occupancy_o = r_occ;

endmodule
